// File: rtl/rgb_pwm_fade.sv
// RGB LED PWM driver with per-channel fade engine and
// current-source power-up sequencing for the LED hard macro.
module rgb_pwm_fade #(
  parameter int NCH    = 3,
  parameter int PWM_W  = 8,
  parameter int DIV_W  = 16,
  parameter int PU_DLY = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             RGBLED_EN,
  input  logic [DIV_W-1:0] TICK_DIV,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [2:0]       CFG_CH,
  input  logic [PWM_W-1:0] CFG_TARGET,
  input  logic [PWM_W-1:0] CFG_STEP,
  output logic             CFG_ERR,
  output logic             RGB_PU,
  output logic             RGB_LEDEN,
  output logic [NCH-1:0]   RGB_PWM,
  output logic [NCH-1:0]   BUSY
);

  localparam int PCW = (PU_DLY > 1) ? $clog2(PU_DLY) : 1;
  localparam logic [PCW-1:0] PU_LAST = PCW'(PU_DLY - 1);
  localparam logic [3:0] NCH4 = 4'(NCH);
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {OFF, PU_WAIT, ON} state_t;

  state_t           state;
  logic [PCW-1:0]   pu_cnt;
  logic [PWM_W-1:0] cnt;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] lim;
  logic             tick;
  logic             run;

  logic [PWM_W-1:0] cur   [NCH];
  logic [PWM_W-1:0] tgt   [NCH];
  logic [PWM_W-1:0] stp   [NCH];
  logic [PWM_W-1:0] act   [NCH];
  logic [PWM_W-1:0] cur_n [NCH];
  logic [PWM_W-1:0] tgt_n [NCH];
  logic [PWM_W-1:0] stp_n [NCH];

  assign CFG_READY = RESETN;
  assign lim  = (TICK_DIV == '0) ? '0 : TICK_DIV - 1'b1;
  // >= keeps the prescaler bounded if TICK_DIV shrinks mid-count
  assign tick = (state == ON) && (presc >= lim);
  assign run  = (state == ON) && RGBLED_EN;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= OFF;
      pu_cnt    <= '0;
      RGB_PU    <= 1'b0;
      RGB_LEDEN <= 1'b0;
    end else if (!RGBLED_EN) begin
      state     <= OFF;
      pu_cnt    <= '0;
      RGB_PU    <= 1'b0;
      RGB_LEDEN <= 1'b0;
    end else begin
      unique case (state)
        OFF: begin
          state  <= PU_WAIT;
          pu_cnt <= '0;
          RGB_PU <= 1'b1;
        end
        PU_WAIT: begin
          if (pu_cnt == PU_LAST) begin
            state     <= ON;
            RGB_LEDEN <= 1'b1;
          end else begin
            pu_cnt <= pu_cnt + 1'b1;
          end
        end
        ON: begin
          state <= ON;
        end
        default: begin
          state     <= OFF;
          RGB_PU    <= 1'b0;
          RGB_LEDEN <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cur_n[i] = cur[i];
      tgt_n[i] = tgt[i];
      stp_n[i] = stp[i];
      if (CFG_VALID && (CFG_CH == 3'(i))) begin
        tgt_n[i] = CFG_TARGET;
        stp_n[i] = CFG_STEP;
        if (CFG_STEP == '0)
          cur_n[i] = CFG_TARGET;
      end else if (tick && (cur[i] != tgt[i])) begin
        if (cur[i] < tgt[i])
          cur_n[i] = (tgt[i] - cur[i] <= stp[i]) ?
                     tgt[i] : cur[i] + stp[i];
        else
          cur_n[i] = (cur[i] - tgt[i] <= stp[i]) ?
                     tgt[i] : cur[i] - stp[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt     <= '0;
      presc   <= '0;
      CFG_ERR <= 1'b0;
      RGB_PWM <= '0;
      BUSY    <= '0;
      for (int i = 0; i < NCH; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
        stp[i] <= '0;
        act[i] <= '0;
      end
    end else begin
      cnt     <= run ? cnt + 1'b1 : '0;
      presc   <= ((state == ON) && !tick) ? presc + 1'b1 : '0;
      CFG_ERR <= CFG_VALID && ({1'b0, CFG_CH} >= NCH4);
      for (int i = 0; i < NCH; i++) begin
        cur[i]     <= cur_n[i];
        tgt[i]     <= tgt_n[i];
        stp[i]     <= stp_n[i];
        BUSY[i]    <= cur_n[i] != tgt_n[i];
        RGB_PWM[i] <= run && (cnt < act[i]);
        // outside ON the output is forced low, so tracking cur is glitch-free
        if (!run || (cnt == CNT_MAX))
          act[i] <= cur[i];
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fade.sv
// Randomized bench for rgb_pwm_fade against a behavioural
// model built from enable run-length and on-time arithmetic.
module tb_rgb_pwm_fade;

  localparam int NCH = 3;
  localparam int PWM_W = 8;
  localparam int DIV_W = 16;
  localparam int PUD = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] tick_div = 16'd10;
  logic             cfg_valid = 1'b0;
  logic [2:0]       cfg_ch = '0;
  logic [PWM_W-1:0] cfg_target = '0;
  logic [PWM_W-1:0] cfg_step = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             rgb_pu;
  logic             rgb_leden;
  logic [NCH-1:0]   rgb_pwm;
  logic [NCH-1:0]   busy;

  rgb_pwm_fade #(
    .NCH(NCH), .PWM_W(PWM_W), .DIV_W(DIV_W), .PU_DLY(PUD)
  ) dut (
    .CLK(clk), .RESETN(rst_n), .RGBLED_EN(en),
    .TICK_DIV(tick_div), .CFG_VALID(cfg_valid),
    .CFG_READY(cfg_ready), .CFG_CH(cfg_ch),
    .CFG_TARGET(cfg_target), .CFG_STEP(cfg_step),
    .CFG_ERR(cfg_err), .RGB_PU(rgb_pu),
    .RGB_LEDEN(rgb_leden), .RGB_PWM(rgb_pwm), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // r = consecutive enabled edges; state and on-time follow from it
  int r = 0;
  int cyc = 0;
  int m_cur [NCH];
  int m_tgt [NCH];
  int m_stp [NCH];
  int m_act [NCH];
  logic [NCH-1:0] m_pwm = '0;
  logic [NCH-1:0] m_busy = '0;
  logic           m_err = 1'b0;
  bit   log_en = 0;
  int   tick_log[$];
  int   tick_at[$];

  function automatic int tdiv();
    return (tick_div == 0) ? 1 : int'(tick_div);
  endfunction

  function automatic bit tick_next();
    int ot;
    if (r <= PUD) return 0;
    ot = r - PUD - 1;
    return (ot % tdiv()) == tdiv() - 1;
  endfunction

  task automatic model_reset();
    r = 0;
    m_pwm = '0;
    m_busy = '0;
    m_err = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = 0; m_tgt[i] = 0;
      m_stp[i] = 0; m_act[i] = 0;
    end
  endtask

  task automatic model_edge();
    int cnt, d, mv, old0;
    bit on, run, tk;
    tk = tick_next();
    on = r > PUD;
    cnt = on ? (r - PUD - 1) % 256 : 0;
    run = on && en;
    old0 = m_cur[0];
    for (int i = 0; i < NCH; i++) begin
      m_pwm[i] = run && (cnt < m_act[i]);
      if (!run || cnt == 255) m_act[i] = m_cur[i];
      if (cfg_valid && cfg_ch == i) begin
        m_tgt[i] = cfg_target;
        m_stp[i] = cfg_step;
        if (cfg_step == 0) m_cur[i] = cfg_target;
      end else if (tk && m_cur[i] != m_tgt[i]) begin
        d = m_tgt[i] - m_cur[i];
        mv = (d > 0) ? d : -d;
        if (mv > m_stp[i]) mv = m_stp[i];
        m_cur[i] = m_cur[i] + ((d > 0) ? mv : -mv);
      end
      m_busy[i] = m_cur[i] != m_tgt[i];
    end
    m_err = cfg_valid && (cfg_ch >= NCH);
    if (log_en && tk && old0 != m_cur[0]) begin
      tick_log.push_back(m_cur[0]);
      tick_at.push_back(cyc);
    end
    r = en ? r + 1 : 0;
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    logic xpu, xled;
    forever begin
      @(negedge clk);
      xpu = r > 0;
      xled = r > PUD;
      vectors++;
      if (rgb_pu !== xpu || rgb_leden !== xled ||
          rgb_pwm !== m_pwm || busy !== m_busy ||
          cfg_err !== m_err || cfg_ready !== rst_n) begin
        miscompares++;
        $display("FAIL cycle %0d outputs (got/exp): pu %b/%b leden %b/%b pwm %b/%b busy %b/%b err %b/%b ready %b/%b",
                 cyc, rgb_pu, xpu, rgb_leden, xled, rgb_pwm, m_pwm,
                 busy, m_busy, cfg_err, m_err, cfg_ready, rst_n);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int tg, input int st);
    cfg_valid = 1'b1;
    cfg_ch = 3'(ch);
    cfg_target = 8'(tg);
    cfg_step = 8'(st);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int k, cnt;
    logic [NCH-1:0] acc;
    repeat (3) step();
    chk("reset_pu", int'(rgb_pu), 0);
    chk("reset_ready", int'(cfg_ready), 0);
    chk("reset_pwm", int'(rgb_pwm), 0);
    rst_n = 1'b1;
    step();
    chk("ready_high", int'(cfg_ready), 1);

    en = 1'b1;
    step();
    chk("pu_rise", int'(rgb_pu), 1);
    chk("leden_early", int'(rgb_leden), 0);
    repeat (3) step();
    chk("leden_pre", int'(rgb_leden), 0);
    step();
    chk("leden_on", int'(rgb_leden), 1);

    write(1, 64, 0);
    repeat (300) step();
    cnt = 0;
    for (int n = 0; n < 256; n++) begin
      step();
      cnt += int'(rgb_pwm[1]);
    end
    chk("ch1_duty64", cnt, 64);

    tick_log.delete();
    tick_at.delete();
    log_en = 1;
    write(0, 100, 30);
    chk("busy0_set", int'(busy[0]), 1);
    k = 1;
    while (busy[0] === 1'b1 && k < 60) begin
      step();
      k++;
    end
    chk("busy0_clear_window", int'(k >= 31 && k <= 40), 1);
    log_en = 0;
    chk("fade_ticks", tick_log.size(), 4);
    if (tick_log.size() == 4) begin
      chk("fade_v0", tick_log[0], 30);
      chk("fade_v1", tick_log[1], 60);
      chk("fade_v2", tick_log[2], 90);
      chk("fade_v3", tick_log[3], 100);
      chk("tick_gap", tick_at[3] - tick_at[2], 10);
    end

    write(5, 200, 0);
    chk("err_pulse", int'(cfg_err), 1);
    chk("err_busy", int'(busy), 0);
    step();
    chk("err_single", int'(cfg_err), 0);

    k = 0;
    while (!tick_next() && k < 20) begin step(); k++; end
    step();
    write(0, 0, 7);
    write(1, 200, 5);
    k = 0;
    while (!tick_next() && k < 20) begin step(); k++; end
    chk("tick_found", int'(k < 20), 1);
    write(2, 50, 10);
    chk("coin_cur2", m_cur[2], 0);
    chk("coin_tgt2", m_tgt[2], 50);
    chk("coin_cur0", m_cur[0], 93);
    chk("coin_cur1", m_cur[1], 69);
    chk("coin_busy", int'(busy), 7);
    repeat (100) step();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      if (r == 0 && !en) tick_div = 16'($urandom_range(0, 12));
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch = ($urandom_range(0, 7) == 0) ?
               3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      cfg_target = 8'($urandom);
      cfg_step = ($urandom_range(0, 3) == 0) ?
                 8'd0 : 8'($urandom_range(1, 40));
      step();
    end
    cfg_valid = 1'b0;

    en = 1'b1;
    write(1, 255, 0);
    write(0, 200, 3);
    k = 0;
    while (rgb_pwm == '0 && k < 2000) begin step(); k++; end
    chk("pwm_seen", int'(rgb_pwm != '0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pwm", int'(rgb_pwm), 0);
    chk("async_pu", int'(rgb_pu), 0);
    chk("async_leden", int'(rgb_leden), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_err", int'(cfg_err), 0);
    chk("async_ready", int'(cfg_ready), 0);
    repeat (2) step();
    rst_n = 1'b1;
    acc = '0;
    for (int n = 0; n < 40; n++) begin
      step();
      acc |= rgb_pwm;
    end
    chk("pwm_after_reset", int'(acc), 0);
    chk("leden_after_reset", int'(rgb_leden), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
